// File: rtl/axis_alex_rx.sv
// -----------------------------------------------------------------------------
// axis_alex_rx
//
// Receiver for the 4-wire Alex control link (data, sclk, latch0, latch1).
// The link is driven from outside the aclk domain, so every line is first
// synchronized and edge-detected. A 16-bit MSB-first word is shifted in on
// each sclk rise, and the frame is closed by a latch strobe, by the first sclk
// of the following frame, or by an idle timeout. Each completed frame is
// offered downstream as one 32-bit AXI-Stream beat.
//
// Ports:
//   aclk           clock
//   aresetn        synchronous active-low reset
//   alex_data[3:0] [0] serial data, [1] sclk, [2] latch0, [3] latch1 (async)
//   m_axis_tdata   {14'd0, load[1:0], word[15:0]}
//   m_axis_tvalid  a beat is being offered
//   m_axis_tready  downstream accepts the offered beat
//   frame_err      one-cycle pulse when a malformed frame is discarded
//   overflow       one-cycle pulse when a completed frame is dropped because
//                  the output register is still held by backpressure
// -----------------------------------------------------------------------------
module axis_alex_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 512
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [3:0]  alex_data,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        frame_err,
    output logic        overflow
);

    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0] FULL = 5'd16;

    logic [3:0]        sync_q [SYNC_STAGES];
    logic [3:0]        sync_out;
    logic [3:0]        dly_q;
    logic [3:0]        rise;
    logic              strobe_rise;
    logic              sclk_rise;

    logic [4:0]        bit_cnt;
    logic [4:0]        bit_cnt_nxt;
    logic [15:0]       shreg;
    logic [15:0]       shreg_nxt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [IDLE_W-1:0] idle_nxt;

    logic              complete;
    logic [1:0]        cmp_load;
    logic [15:0]       cmp_word;
    logic              err;
    logic              timeout_hit;

    // Synchronizer chain for all four link lines, followed by one delay flop
    // so that a rising edge is seen as exactly one cycle of 'rise'.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            dly_q <= '0;
        end else begin
            sync_q[0] <= alex_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= sync_out;
        end
    end

    assign sync_out    = sync_q[SYNC_STAGES-1];
    assign rise        = sync_out & ~dly_q;
    assign sclk_rise   = rise[1];
    assign strobe_rise = rise[2] | rise[3];

    // Frame tracking. A strobe beats an sclk rise in the same cycle (that sclk
    // bit is thrown away), and either beats the idle timeout. A full frame that
    // sees another sclk rise is closed with load=00 and that bit opens the next
    // frame, so back-to-back strobe-less frames lose nothing.
    always_comb begin
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        idle_nxt    = idle_cnt;
        complete    = 1'b0;
        cmp_load    = 2'b00;
        cmp_word    = shreg;
        err         = 1'b0;
        timeout_hit = (bit_cnt != 5'd0) && (idle_cnt == IDLE_LAST);

        if (strobe_rise) begin
            if (bit_cnt == FULL) begin
                complete = 1'b1;
                cmp_load = {rise[3], rise[2]};
            end else begin
                err = 1'b1;
            end
            bit_cnt_nxt = 5'd0;
            idle_nxt    = '0;
        end else if (sclk_rise) begin
            if (bit_cnt == FULL) begin
                complete    = 1'b1;
                bit_cnt_nxt = 5'd1;
            end else begin
                bit_cnt_nxt = bit_cnt + 5'd1;
            end
            shreg_nxt = {shreg[14:0], sync_out[0]};
            idle_nxt  = '0;
        end else if (bit_cnt == 5'd0) begin
            idle_nxt = '0;
        end else if (timeout_hit) begin
            if (bit_cnt == FULL) begin
                complete = 1'b1;
            end else begin
                err = 1'b1;
            end
            bit_cnt_nxt = 5'd0;
            idle_nxt    = '0;
        end else begin
            idle_nxt = idle_cnt + IDLE_W'(1);
        end
    end

    // Frame state registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bit_cnt  <= 5'd0;
            shreg    <= 16'd0;
            idle_cnt <= '0;
        end else begin
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            idle_cnt <= idle_nxt;
        end
    end

    // Single-entry output register. A held beat is never overwritten: a frame
    // completing while the beat is stalled is dropped and reported instead.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_axis_tdata  <= 32'd0;
            m_axis_tvalid <= 1'b0;
            frame_err     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            frame_err <= err;
            overflow  <= complete && m_axis_tvalid && !m_axis_tready;
            if (complete && (!m_axis_tvalid || m_axis_tready)) begin
                m_axis_tdata  <= {14'd0, cmp_load, cmp_word};
                m_axis_tvalid <= 1'b1;
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axis_alex_rx.md
Name: axis_alex_rx

Overview:
- Serial-to-AXI-Stream receiver for the 4-wire Alex control link: data, sclk, latch0, latch1.
- Samples the externally driven link, shifts in a 16-bit MSB-first word, and captures which latch strobe(s) closed the frame.
- Presents each received frame as one 32-bit AXI-Stream beat.
- Used for loopback of the Alex transmitter and for board-side emulation of the Alex filter board.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops per alex_data line (minimum 2).
TIMEOUT_CYCLES, 512, aclk cycles with no sclk rise, while a frame is open, before the frame is closed.

Ports:
aclk  input  1  clock
aresetn  input  1  synchronous active-low reset
alex_data  input  4  [0] serial data, [1] sclk, [2] latch0 strobe, [3] latch1 strobe; asynchronous to aclk
m_axis_tdata  output  32  {14'd0, load[1:0], word[15:0]}
m_axis_tvalid  output  1  frame available
m_axis_tready  input  1  downstream accept
frame_err  output  1  one-cycle pulse on a malformed frame
overflow  output  1  one-cycle pulse when a completed frame is dropped

Behaviour:
- Reset:
  - Reset is synchronous: the aresetn==0 branch is sampled on posedge aclk.
  - Clears synchronizers, edge registers, shift register, bit_cnt, idle_cnt, m_axis_tdata=0, m_axis_tvalid=0, frame_err=0, overflow=0.
  - Reset mid-frame discards the partial frame and any held output beat.
- Input path:
  - Each alex_data bit passes through SYNC_STAGES flops.
  - A further delay flop per line forms rise = sync & ~delayed.
  - Input-to-event latency is SYNC_STAGES+1 cycles.
  - Data is the synchronized alex_data[0], sampled in the same cycle as the sclk rise.
- Frame state:
  - State: bit_cnt 0..16 (5 bits), shreg[15:0].
  - bit_cnt==0 means idle; 1..16 means a frame is open.
- Event priority per cycle: strobe rise > sclk rise > timeout.
- Strobe rise (latch0 rise and/or latch1 rise):
  - If bit_cnt==16: complete the frame with load={latch1_rise, latch0_rise} (both rising together gives 2'b11) and word=shreg. Set bit_cnt=0.
  - If bit_cnt!=16: pulse frame_err, set bit_cnt=0, deliver nothing.
  - An sclk rise in the same cycle is discarded.
- Sclk rise:
  - If bit_cnt<16: shreg={shreg[14:0], data}; bit_cnt+1.
  - If bit_cnt==16: complete the pending frame with load=2'b00 and word=shreg. That sclk bit starts a new frame: shreg={shreg[14:0], data}, bit_cnt=1.
- Timeout:
  - idle_cnt clears on any sclk rise or strobe rise, and whenever bit_cnt==0.
  - Otherwise it increments every cycle.
  - When idle_cnt==TIMEOUT_CYCLES-1 and no rise occurs, the timeout fires:
    - If bit_cnt==16: complete the frame with load=2'b00.
    - If bit_cnt is 1..15: pulse frame_err.
    - In both cases set bit_cnt=0 and idle_cnt=0.
- Output register (single entry):
  - The beat is registered; a completion is visible on m_axis_tvalid the next cycle.
  - tvalid stays high, with tdata stable, until tvalid&tready.
  - Completion while tvalid==0, or while tvalid&tready: load the new beat and set tvalid=1.
  - Completion while tvalid&~tready: drop the new frame, keep the old beat, pulse overflow.
  - tvalid&tready with no completion: tvalid=0; tdata holds its last value.
- frame_err and overflow:
  - Both are registered, high for exactly one cycle per event.
  - Both may pulse in the same cycle.
- m_axis_tdata[31:18] is always 0.

Test Plan:
- Transmitter-shaped frame:
  - Stimulus: 0xA5C3 sent MSB-first, 128 aclk per bit, sclk high in the second half of each bit, then a latch0 pulse.
  - Response: exactly one beat 0x0001A5C3; tready held high; no err or ovf pulses.
- Dual strobe:
  - Stimulus: frame 0x1234 closed by latch0 and latch1 rising in the same cycle.
  - Response: beat 0x00031234.
- Strobe-less frame:
  - Stimulus: 16 bits of 0xFFFF with no strobe, then idle.
  - Response: beat 0x0000FFFF appears TIMEOUT_CYCLES (512) cycles after the synchronized last sclk rise, plus 1 cycle for the output register.
  - Variant: a new frame's first sclk arrives 100 cycles after the last bit. The old frame is delivered immediately and the new frame completes normally.
- Malformed frames:
  - 10 bits then latch1 rise -> one frame_err pulse, no beat.
  - 7 bits then 512 idle cycles -> one frame_err pulse, no beat.
  - The next well-formed 0x0F0F/latch0 frame -> beat 0x00010F0F.
- Backpressure:
  - Stimulus: tready=0; send 0x1111/latch0, then 0x2222/latch1.
  - Response: tvalid stays high with tdata 0x00011111 throughout; overflow pulses once when 0x2222 completes.
  - Raising tready gives exactly one beat, then tvalid=0.
- Reset:
  - Stimulus: aresetn low for 1 cycle after 8 bits of a frame.
  - Response: all outputs 0 on the next edge; the remaining 8 bits plus a strobe produce frame_err and no beat.
